// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared constants and encodings for the writeback port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int STARVE_CW  = 4;

  localparam logic WB_SEL_MEM = 1'b0;
  localparam logic WB_SEL_ALU = 1'b1;

  typedef enum logic [0:0] {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } prio_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module : wb_port_arbiter_if
// Brief  : Requester handshakes and register-file write port of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if import wb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) ();

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wb_sel;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, wb_sel, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, wb_sel, rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_prio_fsm.sv
// ============================================================================
// Module : wb_prio_fsm
// Brief  : Priority state, ALU starvation counter and one-hot grant logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_prio_fsm import wb_pkg::*; #(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int STARVE_MAX = 3
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              alu_valid,
  input  wire logic [REG_AW-1:0] alu_rd,
  input  wire logic              mem_valid,
  input  wire logic [REG_AW-1:0] mem_rd,
  output logic                   grant_alu,
  output logic                   grant_mem
);

  localparam logic [STARVE_CW-1:0] STARVE_LIMIT = STARVE_CW'(STARVE_MAX - 1);
  localparam logic [STARVE_CW-1:0] STARVE_SAT   = {STARVE_CW{1'b1}};

  prio_state_e          state_q, state_d;
  logic [STARVE_CW-1:0] starve_cnt_q, starve_cnt_d;
  logic                 conflict;
  logic                 same_dest;

  // A same-destination pair always writes the older load first so the
  // younger ALU value is what finally lands in the register.
  always_comb begin
    conflict  = alu_valid & mem_valid;
    same_dest = conflict && (alu_rd == mem_rd) && (|alu_rd);
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (conflict) begin
      if ((state_q == ALU_PRI) && !same_dest) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else begin
      grant_alu = alu_valid;
      grant_mem = mem_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (grant_alu) begin
      starve_cnt_d = '0;
      state_d      = MEM_PRI;
    end else if (conflict) begin
      if (starve_cnt_q != STARVE_SAT) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
      if ((state_q == MEM_PRI) && (starve_cnt_q >= STARVE_LIMIT)) begin
        state_d = ALU_PRI;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MEM_PRI;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Arbitrates ALU and load-return writes onto the single register-file
//          write port; optional busy-cycle counter under WB_STALL_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter import wb_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int STARVE_MAX = 3
) (
  input  wire logic      clk,
  input  wire logic      rst,
  wb_port_arbiter_if.slave bus
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  logic              grant_alu;
  logic              grant_mem;
  logic              alu_ready;
  logic              mem_ready;
  logic              busy;
  logic              rf_we_q, rf_we_d;
  logic              wb_sel_q, wb_sel_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  wb_prio_fsm #(
    .REG_AW     (REG_AW),
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_fsm (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (bus.alu_valid),
    .alu_rd    (bus.alu_rd),
    .mem_valid (bus.mem_valid),
    .mem_rd    (bus.mem_rd),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  // Requesters must never see an acceptance while reset is held.
  always_comb begin
    alu_ready = grant_alu & ~rst;
    mem_ready = grant_mem & ~rst;
    busy      = (bus.alu_valid & ~alu_ready) | (bus.mem_valid & ~mem_ready);
  end

  // Writes to x0 are consumed but never enable the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    wb_sel_d   = wb_sel_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_ready) begin
      rf_we_d    = |bus.alu_rd;
      wb_sel_d   = WB_SEL_ALU;
      rf_waddr_d = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end else if (mem_ready) begin
      rf_we_d    = |bus.mem_rd;
      wb_sel_d   = WB_SEL_MEM;
      rf_waddr_d = bus.mem_rd;
      rf_wdata_d = bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      wb_sel_q   <= WB_SEL_MEM;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      wb_sel_q   <= wb_sel_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.busy      = busy;
  assign bus.rf_we     = rf_we_q;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module : tb_wb_port_arbiter
// Brief  : Directed self-checking bench for wb_port_arbiter (STARVE_MAX = 3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_port_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  wb_port_arbiter #(
    .DATA_W     (32),
    .REG_AW     (5),
    .STARVE_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_conflict();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'hA1A1_0003;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    bus.mem_data  = 32'hB2B2_0004;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.rf_we, bus.wb_sel, bus.rf_waddr, bus.rf_wdata} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b sel=%b addr=%0d data=%h required all zero",
               bus.rf_we, bus.wb_sel, bus.rf_waddr, bus.rf_wdata);
    end
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    #1;
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got alu=%b mem=%b required 0 0", bus.alu_ready, bus.mem_ready);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h0000_1234;
    #1;
    checks++;
    if ({bus.alu_ready, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL alu_only_ready got ready=%b busy=%b required 1 0", bus.alu_ready, bus.busy);
    end
    tick();
    bus.alu_valid = 1'b0;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel} !== {1'b1, 5'd5, 32'h0000_1234, 1'b1}) begin
      errors++;
      $display("FAIL alu_only_write got we=%b addr=%0d data=%h sel=%b required 1 5 00001234 1",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel);
    end
  endtask

  task automatic test_mem_only();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({bus.mem_ready, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL mem_only_ready got ready=%b busy=%b required 1 0", bus.mem_ready, bus.busy);
    end
    tick();
    bus.mem_valid = 1'b0;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL mem_only_write got we=%b addr=%0d data=%h sel=%b required 1 7 deadbeef 0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_write got we=%b required 0", bus.rf_we);
    end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_alu;
    exp_alu = 8'b1000_1000;
    do_reset();
    set_conflict();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({bus.alu_ready, bus.mem_ready, bus.busy} !== {exp_alu[i], ~exp_alu[i], 1'b1}) begin
        errors++;
        $display("FAIL starve_grant[%0d] got alu=%b mem=%b busy=%b required %b %b 1",
                 i, bus.alu_ready, bus.mem_ready, bus.busy, exp_alu[i], ~exp_alu[i]);
      end
      tick();
      checks++;
      if ({bus.rf_we, bus.wb_sel, bus.rf_waddr} !== {1'b1, exp_alu[i], (exp_alu[i] ? 5'd3 : 5'd4)}) begin
        errors++;
        $display("FAIL starve_write[%0d] got we=%b sel=%b addr=%0d required 1 %b %0d",
                 i, bus.rf_we, bus.wb_sel, bus.rf_waddr, exp_alu[i], exp_alu[i] ? 3 : 4);
      end
    end
`ifdef WB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd8) begin
      errors++;
      $display("FAIL stall_cnt got %0d required 8", stall_cnt);
    end
`endif
  endtask

  task automatic test_same_dest();
    // Continues from MEM_PRI with a cleared counter; three denials reach ALU_PRI.
    set_conflict();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.mem_ready !== 1'b1) begin
        errors++;
        $display("FAIL same_dest_prep[%0d] got mem_ready=%b required 1", i, bus.mem_ready);
      end
      tick();
    end
    bus.alu_rd   = 5'd9;
    bus.alu_data = 32'hAAAA_0009;
    bus.mem_rd   = 5'd9;
    bus.mem_data = 32'hBBBB_0009;
    #1;
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
      errors++;
      $display("FAIL same_dest_grant got alu=%b mem=%b required 0 1", bus.alu_ready, bus.mem_ready);
    end
    tick();
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel} !== {1'b1, 5'd9, 32'hBBBB_0009, 1'b0}) begin
      errors++;
      $display("FAIL same_dest_first got we=%b addr=%0d data=%h sel=%b required 1 9 bbbb0009 0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel);
    end
    bus.mem_rd   = 5'd10;
    bus.mem_data = 32'hCCCC_000A;
    #1;
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin
      errors++;
      $display("FAIL same_dest_stay_alu_pri got alu=%b mem=%b required 1 0", bus.alu_ready, bus.mem_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel} !== {1'b1, 5'd9, 32'hAAAA_0009, 1'b1}) begin
      errors++;
      $display("FAIL same_dest_final got we=%b addr=%0d data=%h sel=%b required 1 9 aaaa0009 1",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_sel);
    end
    tick();
    bus.mem_valid = 1'b0;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.wb_sel} !== {1'b1, 5'd10, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_mem got we=%b addr=%0d sel=%b required 1 10 0",
               bus.rf_we, bus.rf_waddr, bus.wb_sel);
    end
  endtask

  task automatic test_x0();
    logic [3:0] exp_alu;
    exp_alu = 4'b1000;
    do_reset();
    set_conflict();
    tick();
    tick();
    bus.mem_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %b required 1", bus.alu_ready);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_write got we=%b required 0", bus.rf_we);
    end
    // x0 grant cleared starvation, so three more denials precede the ALU win.
    set_conflict();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.alu_ready, bus.mem_ready} !== {exp_alu[i], ~exp_alu[i]}) begin
        errors++;
        $display("FAIL x0_counter[%0d] got alu=%b mem=%b required %b %b",
                 i, bus.alu_ready, bus.mem_ready, exp_alu[i], ~exp_alu[i]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_conflict();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rf_we, bus.alu_ready, bus.mem_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got we=%b alu=%b mem=%b required 0 0 0",
               bus.rf_we, bus.alu_ready, bus.mem_ready);
    end
`ifdef WB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_stall got %0d required 0", stall_cnt);
    end
`endif
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_grant got alu=%b mem=%b required 0 1", bus.alu_ready, bus.mem_ready);
    end
    tick();
    checks++;
    if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd4}) begin
      errors++;
      $display("FAIL reset_release_write got we=%b addr=%0d required 1 4", bus.rf_we, bus.rf_waddr);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_alu_only();
    test_mem_only();
    test_starvation();
    test_same_dest();
    test_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
